// File: rtl/xcom_link_tx.sv
// XCOM link serial transmitter: captures one command packet over a four-phase
// req/ack handshake and sends it MSB-first on a data + toggle-clock pair.
module xcom_link_tx #(
  parameter int GAP_CYC = 32
) (
  input  logic        x_clk_i,
  input  logic        x_rst_i,
  input  logic        tx_req_i,
  output logic        tx_ack_o,
  input  logic [3:0]  tx_cmd_i,
  input  logic [3:0]  tx_dst_i,
  input  logic [31:0] tx_data_i,
  input  logic [2:0]  tx_div_i,
  output logic        tx_ready_o,
  output logic        tx_busy_o,
  output logic        tx_dt_o,
  output logic        tx_ck_o
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e        state_q, state_d;
  logic [39:0]   sr_q, sr_d;
  logic          ck_q, ck_d;
  logic          ack_q, ack_d;
  logic          half_q, half_d;
  logic [2:0]    hcnt_q, hcnt_d;
  logic [2:0]    div_q, div_d;
  logic [5:0]    bcnt_q, bcnt_d;
  logic [5:0]    last_q, last_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          capture;
  logic [31:0]   payload;
  logic [5:0]    last_idx;

  // Left-justify the payload under the header and pick the index of the final bit.
  always_comb begin
    payload  = '0;
    last_idx = 6'd7;
    case (tx_cmd_i[2:1])
      2'b00:   begin payload = '0;                        last_idx = 6'd7;  end
      2'b01:   begin payload = {tx_data_i[7:0], 24'h0};   last_idx = 6'd15; end
      2'b10:   begin payload = {tx_data_i[15:0], 16'h0};  last_idx = 6'd23; end
      default: begin payload = tx_data_i;                 last_idx = 6'd39; end
    endcase
  end

  assign capture = (state_q == IDLE) && tx_req_i && !ack_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ck_d    = ck_q;
    half_d  = half_q;
    hcnt_d  = hcnt_q;
    div_d   = div_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    gcnt_d  = gcnt_q;
    ack_d   = ack_q;
    if (capture)        ack_d = 1'b1;
    else if (!tx_req_i) ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture) begin
          sr_d    = {tx_cmd_i, tx_dst_i, payload};
          last_d  = last_idx;
          div_d   = tx_div_i;
          hcnt_d  = '0;
          half_d  = 1'b0;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // First half of a bit ends with the clock toggle, second half with the shift.
        if (hcnt_q == div_q) begin
          hcnt_d = '0;
          half_d = !half_q;
          if (!half_q) begin
            ck_d = !ck_q;
          end else if (bcnt_q == last_q) begin
            sr_d    = '0;
            gcnt_d  = '0;
            state_d = GAP;
          end else begin
            sr_d   = {sr_q[38:0], 1'b0};
            bcnt_d = bcnt_q + 6'd1;
          end
        end else begin
          hcnt_d = hcnt_q + 3'd1;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) state_d = IDLE;
        else                    gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge x_clk_i) begin
    if (x_rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      ck_q    <= 1'b0;
      ack_q   <= 1'b0;
      half_q  <= 1'b0;
      hcnt_q  <= '0;
      div_q   <= '0;
      bcnt_q  <= '0;
      last_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ck_q    <= ck_d;
      ack_q   <= ack_d;
      half_q  <= half_d;
      hcnt_q  <= hcnt_d;
      div_q   <= div_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign tx_dt_o    = sr_q[39];
  assign tx_ck_o    = ck_q;
  assign tx_ack_o   = ack_q;
  assign tx_busy_o  = (state_q != IDLE);
  assign tx_ready_o = (state_q == IDLE) && !ack_q;

endmodule

// File: tb/tb_xcom_link_tx.sv
// Directed bench for xcom_link_tx: serial framing, bit timing, handshake and reset.
module tb_xcom_link_tx;

  localparam int GAP_CYC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_req_i;
  logic        tx_ack_o;
  logic [3:0]  tx_cmd_i;
  logic [3:0]  tx_dst_i;
  logic [31:0] tx_data_i;
  logic [2:0]  tx_div_i;
  logic        tx_ready_o;
  logic        tx_busy_o;
  logic        tx_dt_o;
  logic        tx_ck_o;

  int n_chk  = 0;
  int n_fail = 0;

  xcom_link_tx #(.GAP_CYC(GAP_CYC)) dut (
    .x_clk_i   (clk),
    .x_rst_i   (rst),
    .tx_req_i  (tx_req_i),
    .tx_ack_o  (tx_ack_o),
    .tx_cmd_i  (tx_cmd_i),
    .tx_dst_i  (tx_dst_i),
    .tx_data_i (tx_data_i),
    .tx_div_i  (tx_div_i),
    .tx_ready_o(tx_ready_o),
    .tx_busy_o (tx_busy_o),
    .tx_dt_o   (tx_dt_o),
    .tx_ck_o   (tx_ck_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one packet and checks serial data, toggle timing, ack drop and gap length.
  task automatic send_pkt(input string tag, input logic [3:0] cmd, input logic [3:0] dst,
                          input logic [31:0] data, input logic [2:0] div, input int n,
                          input logic [63:0] exp, input bit scramble);
    logic [63:0] obs;
    logic        ck0, prevck, prevdt;
    int          h, toggles, terr, berr, gerr;
    @(negedge clk);
    ck0 = tx_ck_o;
    chk({tag, "_ready_before"}, tx_ready_o, 1);
    tx_cmd_i = cmd; tx_dst_i = dst; tx_data_i = data; tx_div_i = div; tx_req_i = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ack_at_C"}, tx_ack_o, 1);
    chk({tag, "_busy_at_C"}, tx_busy_o, 1);
    chk({tag, "_ready_at_C"}, tx_ready_o, 0);
    h = int'(div) + 1;
    obs = 64'(tx_dt_o);
    toggles = 0; terr = 0; berr = 0; gerr = 0;
    if (tx_ck_o !== ck0) terr++;
    prevck = tx_ck_o;
    prevdt = tx_dt_o;
    @(negedge clk);
    tx_req_i = 1'b0;
    if (scramble) begin
      tx_cmd_i = ~cmd; tx_dst_i = ~dst; tx_data_i = ~data; tx_div_i = ~div;
    end
    for (int e = 1; e <= 2 * n * h; e++) begin
      @(posedge clk); #1;
      if (e == 1) chk({tag, "_ack_fall"}, tx_ack_o, 0);
      if (e < 2 * n * h && (e % (2 * h)) == 0) obs = {obs[62:0], tx_dt_o};
      if (tx_dt_o !== prevdt && (e % (2 * h)) != 0) terr++;
      if (tx_ck_o !== prevck) begin
        toggles++;
        if ((e % (2 * h)) != h) terr++;
      end
      if (tx_busy_o !== 1'b1 || tx_ready_o !== 1'b0) berr++;
      prevck = tx_ck_o;
      prevdt = tx_dt_o;
    end
    chk({tag, "_serial_data"}, obs, exp);
    chk({tag, "_ck_toggles"}, 64'(toggles), 64'(n));
    chk({tag, "_timing_errs"}, 64'(terr), 0);
    chk({tag, "_busy_errs"}, 64'(berr), 0);
    chk({tag, "_dt_in_gap"}, tx_dt_o, 0);
    for (int g = 1; g <= GAP_CYC; g++) begin
      @(posedge clk); #1;
      if (g < GAP_CYC && tx_busy_o !== 1'b1) gerr++;
      if (tx_dt_o !== 1'b0 || tx_ck_o !== prevck) gerr++;
    end
    chk({tag, "_gap_errs"}, 64'(gerr), 0);
    chk({tag, "_busy_end"}, tx_busy_o, 0);
    chk({tag, "_ready_end"}, tx_ready_o, 1);
  endtask

  initial begin
    int ackerr, busycyc, herr;
    rst = 1'b1; tx_req_i = 1'b0; tx_cmd_i = '0; tx_dst_i = '0; tx_data_i = '0; tx_div_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dt", tx_dt_o, 0);
    chk("rst_ck", tx_ck_o, 0);
    chk("rst_ack", tx_ack_o, 0);
    chk("rst_busy", tx_busy_o, 0);
    chk("rst_ready", tx_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    send_pkt("hdr_only", 4'b0001, 4'd3, 32'h0, 3'd0, 8, 64'h13, 1'b0);
    send_pkt("pay8", 4'b0010, 4'd0, 32'h0000_00A5, 3'd1, 16, 64'h20A5, 1'b0);
    send_pkt("pay32", 4'b0110, 4'd5, 32'hDEAD_BEEF, 3'd7, 40, 64'h65_DEAD_BEEF, 1'b1);
    send_pkt("pay16", 4'b1100, 4'hA, 32'h1234_ABCD, 3'd2, 24, 64'hCA_ABCD, 1'b1);

    // Held request: exactly one packet (8 bits at H=1 plus the gap = 48 busy cycles).
    @(negedge clk);
    tx_cmd_i = 4'b0001; tx_dst_i = 4'd3; tx_div_i = 3'd0; tx_req_i = 1'b1;
    ackerr = 0; busycyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!tx_ack_o) ackerr++;
      if (tx_busy_o) busycyc++;
    end
    chk("hold_ack_high", 64'(ackerr), 0);
    chk("hold_busy_cycles", 64'(busycyc), 48);
    @(negedge clk);
    tx_req_i = 1'b0;
    @(posedge clk); #1;
    chk("hold_ack_drop", tx_ack_o, 0);
    chk("hold_ready_after_drop", tx_ready_o, 1);

    // Request re-raised during the gap is captured on the first IDLE cycle.
    @(negedge clk);
    tx_req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_req_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    tx_req_i = 1'b1;
    herr = 0;
    for (int e = 21; e <= 47; e++) begin
      @(posedge clk); #1;
      if (tx_busy_o !== 1'b1 || tx_ack_o !== 1'b0) herr++;
    end
    chk("gapreq_held_off", 64'(herr), 0);
    @(posedge clk); #1;
    chk("gapreq_idle_busy", tx_busy_o, 0);
    chk("gapreq_idle_ack", tx_ack_o, 0);
    @(posedge clk); #1;
    chk("gapreq_capture_busy", tx_busy_o, 1);
    chk("gapreq_capture_ack", tx_ack_o, 1);
    @(negedge clk);
    tx_req_i = 1'b0;
    repeat (60) @(posedge clk);

    // Reset at bit 10 of a 0x20FF packet (bit 10 is a 1).
    @(negedge clk);
    tx_cmd_i = 4'b0010; tx_dst_i = 4'd0; tx_data_i = 32'hFF; tx_div_i = 3'd0; tx_req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_req_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_bit10_dt", tx_dt_o, 1);
    chk("midrst_busy_before", tx_busy_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_dt", tx_dt_o, 0);
    chk("midrst_ck", tx_ck_o, 0);
    chk("midrst_ack", tx_ack_o, 0);
    chk("midrst_busy", tx_busy_o, 0);
    chk("midrst_ready", tx_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (GAP_CYC) @(posedge clk);
    send_pkt("after_rst", 4'b1100, 4'hA, 32'h1234_ABCD, 3'd2, 24, 64'hCA_ABCD, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xcom_link_tx.md
# xcom_link_tx

Serial transmitter for the two-wire XCOM link (data + toggle-clock). It accepts one command packet from the local command logic through a four-phase req/ack handshake and serialises it MSB-first onto `tx_dt_o`/`tx_ck_o`. Every bit is marked by one transition of `tx_ck_o`. After each packet it enforces an idle gap so the far-end receiver can complete its own request/ack cycle. It sits beside the link receiver in the XCOM block and drives the board-level wires.

## Interface
- `GAP_CYC`, default 32: idle cycles after the last bit before a new packet is accepted. Minimum 32; the far-end timeout is 31 cycles.
- `x_clk_i`  in  1  link clock.
- `x_rst_i`  in  1  synchronous reset, active-high.
- `tx_req_i`  in  1  packet request. `tx_cmd_i`, `tx_dst_i` and `tx_data_i` are valid while it is high.
- `tx_ack_o`  out  1  packet captured (four-phase ack).
- `tx_cmd_i`  in  4  command. Bits [2:1] select the payload length.
- `tx_dst_i`  in  4  destination ID. 0 means broadcast.
- `tx_data_i`  in  32  payload, right-aligned.
- `tx_div_i`  in  3  half-bit period minus 1, giving H = `tx_div_i`+1 cycles.
- `tx_ready_o`  out  1  in IDLE; a request is accepted this cycle if asserted.
- `tx_busy_o`  out  1  packet or gap in progress.
- `tx_dt_o`  out  1  serial data.
- `tx_ck_o`  out  1  serial clock. Each transition marks one bit.

## Operation
- Header is {`tx_cmd_i`, `tx_dst_i`}, 8 bits, sent MSB first.
- Payload length is set by `tx_cmd_i[2:1]`:
  - 00: 0 bits, N = 8 total.
  - 01: 8 bits, from `tx_data_i[7:0]`, N = 16.
  - 10: 16 bits, from `tx_data_i[15:0]`, N = 24.
  - 11: 32 bits, N = 40.
- Payload bits are sent MSB first, after the header.
- Capture: load a 40-bit shift register with {header, `tx_data_i` << (32−payload bits)}. Latch N and H. `tx_dt_o` always outputs shift-register bit [39]. Later changes to the inputs or `tx_div_i` have no effect on the packet in flight.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: `tx_ready_o`=1 and `tx_dt_o`=0. If `tx_req_i`=1 and `tx_ack_o`=0: capture and go to SHIFT.
  - SHIFT: each bit lasts 2H cycles. Data is presented first; `tx_ck_o` toggles at the midpoint. After bit N−1, go to GAP.
  - GAP: `tx_dt_o`=0. Count GAP_CYC cycles, then go to IDLE.
- `tx_ack_o` is set at the capture edge. It is cleared on the first edge where `tx_req_i`=0, independent of FSM state.
- Holding `tx_req_i` high never sends a second packet; a new packet requires `tx_req_i` low, then high again. A request raised during SHIFT or GAP waits until IDLE.
- `tx_ck_o` has no return-to-idle level; it keeps whatever level it reached between packets. It always toggles exactly N times per packet.
- Counters:
  - half-period counter: 3 bits, counts 0..H−1.
  - bit counter: 6 bits, counts 0..39.
  - gap counter: ceil(log2(GAP_CYC+1)) bits.
  - No counter wraps within a packet.
- `tx_busy_o` = (state ≠ IDLE). `tx_ready_o` = (state == IDLE) & !`tx_ack_o`.

## Timing
- Reset values: `tx_dt_o`=0, `tx_ck_o`=0, `tx_ack_o`=0, `tx_busy_o`=0, `tx_ready_o`=1 in the cycle after reset. State resets to IDLE.
- C is the capture edge (`tx_req_i` sampled high in IDLE).
- Bit k (k = 0..N−1):
  - `tx_dt_o` takes its value at edge C+2kH.
  - `tx_ck_o` toggles at edge C+(2k+1)H.
  - Data is therefore stable at least H ≥ 1 cycle before, and H cycles after, each clock transition.
- At edge C+2NH: `tx_dt_o`=0 and the FSM enters GAP.
- At edge C+2NH+GAP_CYC: the FSM enters IDLE and `tx_busy_o` falls.
- Maximum bit period is 16 cycles (`tx_div_i`=7). This stays below the 31-cycle receiver timeout.
- `tx_ack_o` rises at C and falls one edge after `tx_req_i` is sampled low. Minimum pulse: 1 cycle.
- Reset mid-packet: the next edge returns to IDLE with all outputs at reset values. If `tx_ck_o` was 1, this produces one spurious transition; the far end discards the partial packet by timeout. Firmware must wait at least GAP_CYC cycles after reset before requesting.
- Request in the same cycle as the last GAP cycle: not accepted. It is accepted on the first IDLE cycle.

## Test plan
- Header-only packet: cmd=4'b0001, dst=3, div=0 → `tx_dt_o` serial 0,0,0,1,0,0,1,1. `tx_ck_o` toggles at C+1, C+3, …, C+15 (8 transitions). `tx_ready_o` rises at C+16+GAP_CYC.
- 8-bit payload: cmd=4'b0010, dst=0, data=0x000000A5, div=1 → 16 bits: 00100000 then 10100101. Toggles every 4 cycles, first toggle at C+2.
- 32-bit payload: cmd=4'b0110, dst=5, data=0xDEADBEEF, div=7 → 40 transitions 16 cycles apart. The data sequence is header 0x65 then 0xDEADBEEF, MSB first. Changing data and div mid-packet has no effect.
- Handshake: hold `tx_req_i` high for 300 cycles → exactly one packet, `tx_ack_o` high throughout. Drop req → ack low one edge later. Re-raise req during GAP → capture occurs on the first IDLE cycle.
- Reset mid-packet at bit 10: all outputs return to 0 next edge, FSM in IDLE. A subsequent packet transmits correctly.
- Loopback into the link receiver, same clock, all 4 lengths, all div values, dst = own and broadcast → receiver presents matching cmd/data. No timeout occurs and no packet is lost across back-to-back requests.
